// File: rtl/reg_file_2r1w_clr.sv
// Two-read/one-write register file with optional write bypass, optional hardwired-zero r0,
// and a sequential clear sweep (one register per cycle) after reset or on request.
module reg_file_2r1w_clr #(
  parameter int W       = 8,
  parameter int A       = 4,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         WriteEn,
  input  logic [A-1:0] WriteAddr,
  input  logic [W-1:0] DataIn,
  input  logic [A-1:0] ReadAddrA,
  input  logic [A-1:0] ReadAddrB,
  input  logic         ClearReq,
  output logic [W-1:0] DataOutA,
  output logic [W-1:0] DataOutB,
  output logic         Busy
);

  localparam int             DEPTH    = 2 ** A;
  localparam logic [0:0]     IDLE     = 1'b0;
  localparam logic [0:0]     CLEAR    = 1'b1;
  localparam logic [A-1:0]   IDX_LAST = {A{1'b1}};

  logic [0:0]   state_r;
  logic [A-1:0] idx_r;
  logic [W-1:0] mem_r [DEPTH];
  logic         busy_s;
  logic         wr_ok_s;
  logic [W-1:0] rd_a_s;
  logic [W-1:0] rd_b_s;

  function automatic logic is_zero_reg(input logic [A-1:0] addr);
    return (ZERO_R0 != 0) && (addr == {A{1'b0}});
  endfunction

  // Read priority: sweep blanks reads, then hardwired r0, then bypass, then storage.
  function automatic logic [W-1:0] read_port(
    input logic         busy,
    input logic [A-1:0] addr,
    input logic         we,
    input logic [A-1:0] waddr,
    input logic [W-1:0] din,
    input logic [W-1:0] stored
  );
    logic [W-1:0] data;
    if (busy) begin
      data = {W{1'b0}};
    end else if (is_zero_reg(addr)) begin
      data = {W{1'b0}};
    end else if ((BYPASS != 0) && we && (waddr == addr)) begin
      data = din;
    end else begin
      data = stored;
    end
    return data;
  endfunction

  assign busy_s  = (state_r == CLEAR);
  assign wr_ok_s = WriteEn && !busy_s && !is_zero_reg(WriteAddr);

  // Sweep controller: reset or an idle clear request restarts the index at zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= CLEAR;
      idx_r   <= {A{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (ClearReq) begin
            state_r <= CLEAR;
            idx_r   <= {A{1'b0}};
          end else begin
            state_r <= IDLE;
            idx_r   <= idx_r;
          end
        end
        CLEAR: begin
          idx_r <= idx_r + A'(1);
          if (idx_r == IDX_LAST) begin
            state_r <= IDLE;
          end else begin
            state_r <= CLEAR;
          end
        end
        default: begin
          state_r <= CLEAR;
          idx_r   <= {A{1'b0}};
        end
      endcase
    end
  end

  // Storage: the reset edge leaves contents alone; the sweep owns the array while busy.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (busy_s) begin
        mem_r[idx_r] <= {W{1'b0}};
      end else if (wr_ok_s) begin
        mem_r[WriteAddr] <= DataIn;
      end
    end
  end

  // Combinational read ports.
  always_comb begin
    rd_a_s = read_port(busy_s, ReadAddrA, WriteEn, WriteAddr, DataIn, mem_r[ReadAddrA]);
    rd_b_s = read_port(busy_s, ReadAddrB, WriteEn, WriteAddr, DataIn, mem_r[ReadAddrB]);
  end

  assign DataOutA = rd_a_s;
  assign DataOutB = rd_b_s;
  assign Busy     = busy_s;

endmodule

// File: tb/tb_reg_file_2r1w_clr.sv
// Scoreboard bench: dut1 has bypass and a writable r0, dut2 has no bypass and a hardwired-zero r0.
module tb_reg_file_2r1w_clr;

  logic       Clk = 1'b0;
  logic       Reset, WriteEn, ClearReq;
  logic [3:0] WriteAddr, ReadAddrA, ReadAddrB;
  logic [7:0] DataIn;
  logic [7:0] a1, b1, a2, b2;
  logic       busy1, busy2;

  typedef struct {
    string      name;
    int         cyc;
    logic [7:0] ea1, eb1, ea2, eb2;
    logic       ebusy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc_cnt  = 0;
  int   checks   = 0;
  int   failures = 0;

  reg_file_2r1w_clr #(.W(8), .A(4), .BYPASS(1), .ZERO_R0(0)) dut1 (
    .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .WriteAddr(WriteAddr), .DataIn(DataIn),
    .ReadAddrA(ReadAddrA), .ReadAddrB(ReadAddrB), .ClearReq(ClearReq),
    .DataOutA(a1), .DataOutB(b1), .Busy(busy1)
  );

  reg_file_2r1w_clr #(.W(8), .A(4), .BYPASS(0), .ZERO_R0(1)) dut2 (
    .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .WriteAddr(WriteAddr), .DataIn(DataIn),
    .ReadAddrA(ReadAddrA), .ReadAddrB(ReadAddrB), .ClearReq(ClearReq),
    .DataOutA(a2), .DataOutB(b2), .Busy(busy2)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string n, input string f, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s: got 0x%02h expected 0x%02h", n, f, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so each expectation is checked mid-cycle.
  always @(negedge Clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc != cyc_cnt) begin
        checks++;
        failures++;
        $display("FAIL %s.stale: cycle %0d expected at cycle %0d", mon_e.name, cyc_cnt, mon_e.cyc);
      end else begin
        chk(mon_e.name, "busy1", {7'b0, busy1}, {7'b0, mon_e.ebusy});
        chk(mon_e.name, "busy2", {7'b0, busy2}, {7'b0, mon_e.ebusy});
        chk(mon_e.name, "a1", a1, mon_e.ea1);
        chk(mon_e.name, "b1", b1, mon_e.eb1);
        chk(mon_e.name, "a2", a2, mon_e.ea2);
        chk(mon_e.name, "b2", b2, mon_e.eb2);
      end
    end
  end

  task automatic drive(input logic we, input logic [3:0] wa, input logic [7:0] d,
                       input logic [3:0] ra, input logic [3:0] rb, input logic clr, input logic rst);
    WriteEn = we; WriteAddr = wa; DataIn = d;
    ReadAddrA = ra; ReadAddrB = rb; ClearReq = clr; Reset = rst;
  endtask

  task automatic expect_out(input string n, input logic [7:0] ea1, input logic [7:0] eb1,
                            input logic [7:0] ea2, input logic [7:0] eb2, input logic bz);
    sb.push_back('{n, cyc_cnt, ea1, eb1, ea2, eb2, bz});
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b1);
    tick();

    // Post-reset sweep: 16 busy cycles, then everything reads zero.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'd0, 8'h00, 4'(i), 4'(15 - i), 1'b0, 1'b0);
      expect_out("t1_busy", 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'd0, 8'h00, 4'(i), 4'(15 - i), 1'b0, 1'b0);
      expect_out("t1_read", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      tick();
    end

    // Write r3 with both ports reading it.
    drive(1'b1, 4'd3, 8'h5A, 4'd3, 4'd3, 1'b0, 1'b0);
    expect_out("t2_wr", 8'h5A, 8'h5A, 8'h00, 8'h00, 1'b0);
    tick();
    drive(1'b0, 4'd0, 8'h00, 4'd3, 4'd3, 1'b0, 1'b0);
    expect_out("t2_rd", 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1'b0);
    tick();

    // r0 behaviour: writable in dut1, hardwired zero in dut2.
    drive(1'b1, 4'd0, 8'hFF, 4'd0, 4'd3, 1'b0, 1'b0);
    expect_out("t3_wr0", 8'hFF, 8'h5A, 8'h00, 8'h5A, 1'b0);
    tick();
    drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0);
    expect_out("t3_rd0", 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0);
    tick();
    drive(1'b1, 4'd1, 8'h11, 4'd1, 4'd0, 1'b0, 1'b0);
    expect_out("t3_wr1", 8'h11, 8'hFF, 8'h00, 8'h00, 1'b0);
    tick();
    drive(1'b0, 4'd0, 8'h00, 4'd1, 4'd1, 1'b0, 1'b0);
    expect_out("t3_rd1", 8'h11, 8'h11, 8'h11, 8'h11, 1'b0);
    tick();

    // Dual-port independence with a write to the B address.
    drive(1'b1, 4'd2, 8'h21, 4'd2, 4'd9, 1'b0, 1'b0);
    expect_out("t6_wr2", 8'h21, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    drive(1'b1, 4'd9, 8'h9C, 4'd2, 4'd9, 1'b0, 1'b0);
    expect_out("t6_wr9a", 8'h21, 8'h9C, 8'h21, 8'h00, 1'b0);
    tick();
    drive(1'b1, 4'd9, 8'h33, 4'd2, 4'd9, 1'b0, 1'b0);
    expect_out("t6_wr9b", 8'h21, 8'h33, 8'h21, 8'h9C, 1'b0);
    tick();
    drive(1'b0, 4'd0, 8'h00, 4'd2, 4'd9, 1'b0, 1'b0);
    expect_out("t6_rd", 8'h21, 8'h33, 8'h21, 8'h33, 1'b0);
    tick();

    // Fill, read back, then clear with a concurrent write.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 8'h10 + 8'(i), 4'd0, 4'd0, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'd0, 8'h00, 4'(i), 4'(15 - i), 1'b0, 1'b0);
      expect_out("t4_fill", 8'h10 + 8'(i), 8'h10 + 8'(15 - i),
                 (i == 0) ? 8'h00 : 8'h10 + 8'(i),
                 (i == 15) ? 8'h00 : 8'h10 + 8'(15 - i), 1'b0);
      tick();
    end
    drive(1'b1, 4'd5, 8'h77, 4'd5, 4'd7, 1'b1, 1'b0);
    expect_out("t4_req", 8'h77, 8'h17, 8'h15, 8'h17, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(i == 8, 4'd7, 8'hAA, 4'd7, 4'd5, i == 3, 1'b0);
      expect_out("t4_busy", 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'd0, 8'h00, 4'(i), 4'(15 - i), 1'b0, 1'b0);
      expect_out("t4_clr", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      tick();
    end

    // Reset part-way through a sweep restarts it from index zero.
    drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b1, 1'b0);
    expect_out("t5_req", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 4'd0, 8'h00, 4'(k), 4'(k), k == 3, k == 9);
      expect_out("t5_pre", 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      tick();
    end
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 4'd0, 8'h00, 4'(k), 4'(k), 1'b0, 1'b0);
      expect_out("t5_post", 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      tick();
    end
    drive(1'b1, 4'd4, 8'h4C, 4'd4, 4'd0, 1'b0, 1'b0);
    expect_out("t5_done", 8'h4C, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();

    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
